ram_delay_mc: RTL and testbench

Multi-channel, write-driven RAM delay line. It is the next generation of ram_delay, generalised to P_NCHAN parallel channels that share one write pointer. It adds a hardware fill state machine that preloads every RAM location with d_reset after reset, after a clear request, or when the delay changes. A primed flag marks when qo carries real data rather than fill data. It sits in the sample pipeline wherever a window/baseline needs the sample taken exactly n writes earlier.

---
 rtl/ram_delay_mc_if.sv | 15 +
 rtl/ram_delay_mc.sv | 116 +++++++++++
 tb/tb_ram_delay_mc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_delay_mc_if.sv
// Sample-stream bundle for ram_delay_mc: write strobe and data in, delayed pair and status out.
interface ram_delay_mc_if #(
    parameter int unsigned P_W = 56
) ();
    logic           wr;
    logic [P_W-1:0] d;
    logic [P_W-1:0] qn;
    logic [P_W-1:0] qo;
    logic           valid;
    logic           busy;
    logic           primed;

    modport master (output wr, d, input qn, qo, valid, busy, primed);
    modport slave  (input wr, d, output qn, qo, valid, busy, primed);
endinterface

// File: rtl/ram_delay_mc.sv
// Multi-channel write-driven RAM delay line: qo is the sample accepted n writes before qn.
// A fill FSM preloads every location with d_reset after reset, clear, or a delay change.
module ram_delay_mc #(
    parameter int unsigned P_NBITS_DATA = 14,
    parameter int unsigned P_NBITS_ADDR = 9,
    parameter int unsigned P_NCHAN      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [P_NBITS_DATA-1:0] d_reset,
    input  logic [P_NBITS_ADDR-1:0] n,
    ram_delay_mc_if.slave           bus
);
    localparam int unsigned W     = P_NCHAN * P_NBITS_DATA;
    localparam int unsigned Depth = 2 ** P_NBITS_ADDR;

    localparam logic [P_NBITS_ADDR-1:0] LastAddr = '1;
    localparam logic [P_NBITS_ADDR-1:0] AddrOne  = 1;

    localparam logic [0:0] StFill = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [W-1:0]            r_mem [Depth];
    logic [0:0]              r_state;
    logic [P_NBITS_ADDR-1:0] r_fill_cnt;
    logic [P_NBITS_ADDR-1:0] r_wptr;
    logic [P_NBITS_ADDR-1:0] r_wr_cnt;
    logic [P_NBITS_ADDR-1:0] r_n_lat;
    logic [W-1:0]            r_qn;
    logic [W-1:0]            r_qo;
    logic                    r_valid;
    logic                    r_primed;

    logic                    w_trigger;
    logic                    w_accept;
    logic                    w_mem_we;
    logic [P_NBITS_ADDR-1:0] w_mem_addr;
    logic [W-1:0]            w_mem_wdata;

    always_comb begin
        w_trigger   = (r_state == StRun) && (clear || (n != r_n_lat));
        w_accept    = (r_state == StRun) && bus.wr && !w_trigger;
        // Bypass (n_lat == 0) never touches the RAM.
        w_mem_we    = rst && ((r_state == StFill) || (w_accept && (r_n_lat != '0)));
        w_mem_addr  = (r_state == StFill) ? r_fill_cnt : r_wptr;
        w_mem_wdata = (r_state == StFill) ? {P_NCHAN{d_reset}} : bus.d;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StFill;
            r_fill_cnt <= '0;
            r_wptr     <= '0;
            r_wr_cnt   <= '0;
            r_n_lat    <= '0;
            r_qn       <= '0;
            r_qo       <= '0;
            r_valid    <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StFill: begin
                    if (clear) begin
                        r_fill_cnt <= '0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + AddrOne;
                        if (r_fill_cnt == LastAddr) begin
                            r_state  <= StRun;
                            r_n_lat  <= n;
                            r_wptr   <= '0;
                            r_wr_cnt <= '0;
                            r_primed <= (n == '0);
                        end
                    end
                end
                StRun: begin
                    if (w_trigger) begin
                        r_state    <= StFill;
                        r_fill_cnt <= '0;
                        r_primed   <= 1'b0;
                    end else if (bus.wr) begin
                        r_valid <= 1'b1;
                        r_qn    <= bus.d;
                        if (r_n_lat == '0) begin
                            r_qo <= bus.d;
                        end else begin
                            // Read-before-write: the slot still holds the sample from n_lat writes ago.
                            r_qo   <= r_mem[r_wptr];
                            r_wptr <= (r_wptr == r_n_lat - AddrOne) ? '0 : r_wptr + AddrOne;
                            if (r_wr_cnt == r_n_lat) begin
                                r_primed <= 1'b1;
                            end else begin
                                r_wr_cnt <= r_wr_cnt + AddrOne;
                            end
                        end
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

    assign bus.qn     = r_qn;
    assign bus.qo     = r_qo;
    assign bus.valid  = r_valid;
    assign bus.busy   = (r_state == StFill);
    assign bus.primed = r_primed;
endmodule

// File: tb/tb_ram_delay_mc.sv
// Directed bench for ram_delay_mc: fill timing, delay/priming, gaps, bypass, re-fill triggers.
module tb_ram_delay_mc;
    localparam int unsigned NB = 14;
    localparam int unsigned NA = 9;
    localparam int unsigned NC = 4;
    localparam int unsigned W  = NB * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic [NB-1:0] d_reset;
    logic [NA-1:0] n;

    int vecs = 0;
    int errs = 0;

    ram_delay_mc_if #(.P_W(W)) bus ();

    ram_delay_mc #(
        .P_NBITS_DATA(NB),
        .P_NBITS_ADDR(NA),
        .P_NCHAN     (NC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .d_reset(d_reset),
        .n      (n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    // ch0 = k, ch1 = k+1000, ch2 = k+2000, ch3 = k+100
    function automatic logic [W-1:0] pk(input int k);
        return {14'(k + 100), 14'(k + 2000), 14'(k + 1000), 14'(k)};
    endfunction

    function automatic logic [W-1:0] fillv(input logic [NB-1:0] v);
        return {NC{v}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; valid/primed must stay low while busy.
    task automatic wait_fill(input string tag, input int exp_cycles);
        int  c   = 0;
        logic bad = 1'b0;
        do begin
            tick();
            c++;
            if (bus.busy && (bus.valid || bus.primed)) bad = 1'b1;
        end while (bus.busy && c < 700);
        chki({tag, " busy cycles"}, c, exp_cycles);
        chk1({tag, " quiet while busy"}, bad, 1'b0);
    endtask

    task automatic write(input string tag, input logic [W-1:0] dv,
                         input logic [W-1:0] exp_qo, input logic exp_primed);
        bus.wr = 1'b1;
        bus.d  = dv;
        tick();
        bus.wr = 1'b0;
        chk1({tag, " valid"}, bus.valid, 1'b1);
        chk({tag, " qn"}, bus.qn, dv);
        chk({tag, " qo"}, bus.qo, exp_qo);
        chk1({tag, " primed"}, bus.primed, exp_primed);
    endtask

    task automatic run_s2(input string tag);
        for (int k = 0; k < 20; k++) begin
            write($sformatf("%s w%0d", tag, k), pk(k),
                  (k < 16) ? fillv(14'h2A) : pk(k - 16), k >= 16);
        end
        tick();
        chk1({tag, " valid after burst"}, bus.valid, 1'b0);
    endtask

    initial begin
        bus.wr  = 1'b0;
        bus.d   = '0;
        d_reset = 14'h2A;
        n       = 9'd16;

        // 1: reset values and first fill
        repeat (3) tick();
        chk1("rst busy", bus.busy, 1'b1);
        chk("rst qn", bus.qn, '0);
        chk("rst qo", bus.qo, '0);
        chk1("rst valid", bus.valid, 1'b0);
        chk1("rst primed", bus.primed, 1'b0);
        rst = 1'b1;
        wait_fill("fill0", 512);
        chk("fill0 qn", bus.qn, '0);
        chk("fill0 qo", bus.qo, '0);
        chk1("fill0 primed", bus.primed, 1'b0);

        // 2: back-to-back writes, n=16
        run_s2("s2");

        // 3: writes with gaps; delay counts writes
        for (int k = 20; k < 60; k++) begin
            int g;
            write($sformatf("s3 w%0d", k), pk(k), pk(k - 16), 1'b1);
            g = (k % 2 == 0) ? 1 : int'($urandom_range(1, 4));
            for (int i = 0; i < g; i++) begin
                tick();
                chk1($sformatf("s3 gap valid k%0d", k), bus.valid, 1'b0);
            end
        end

        // 5: delay change 16->8 with a coincident write, which is dropped
        n      = 9'd8;
        bus.wr = 1'b1;
        bus.d  = pk(999);
        tick();
        bus.wr = 1'b0;
        chk1("s5 dropped valid", bus.valid, 1'b0);
        chk1("s5 busy", bus.busy, 1'b1);
        chk1("s5 primed", bus.primed, 1'b0);
        chk("s5 qn hold", bus.qn, pk(59));
        wait_fill("s5 fill", 512);
        chk("s5 qn hold after fill", bus.qn, pk(59));
        for (int k = 0; k < 12; k++) begin
            write($sformatf("s5 w%0d", k), pk(300 + k),
                  (k < 8) ? fillv(14'h2A) : pk(300 + k - 8), k >= 8);
        end

        // 4: bypass n=0, then n=1 with a different fill value
        n = 9'd0;
        tick();
        chk1("s4 n0 busy", bus.busy, 1'b1);
        wait_fill("s4 n0 fill", 512);
        chk1("s4 n0 primed at entry", bus.primed, 1'b1);
        for (int k = 0; k < 4; k++) begin
            write($sformatf("s4 n0 w%0d", k), pk(500 + k), pk(500 + k), 1'b1);
        end
        n       = 9'd1;
        d_reset = 14'h155;
        tick();
        chk1("s4 n1 primed cleared", bus.primed, 1'b0);
        wait_fill("s4 n1 fill", 512);
        chk1("s4 n1 primed at entry", bus.primed, 1'b0);
        write("s4 n1 w0", pk(600), fillv(14'h155), 1'b0);
        for (int k = 1; k < 4; k++) begin
            write($sformatf("s4 n1 w%0d", k), pk(600 + k), pk(600 + k - 1), 1'b1);
        end

        // 6: clear mid-fill restarts the count, then a one-cycle reset mid-run
        d_reset = 14'h2A;
        n       = 9'd16;
        tick();
        repeat (300) tick();
        chk1("s6 busy before clear", bus.busy, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_fill("s6 clear fill", 512);
        write("s6 pre-rst w0", pk(700), fillv(14'h2A), 1'b0);
        write("s6 pre-rst w1", pk(701), fillv(14'h2A), 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk1("s6 rst busy", bus.busy, 1'b1);
        chk("s6 rst qn", bus.qn, '0);
        chk("s6 rst qo", bus.qo, '0);
        chk1("s6 rst valid", bus.valid, 1'b0);
        chk1("s6 rst primed", bus.primed, 1'b0);
        wait_fill("s6 rst fill", 512);
        run_s2("s6 repeat");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
